// File: rtl/gb_probe_pkg.sv
// Shared types and constants for the Game Boy clock probe.
// Optional single-step support is enabled by defining GB_CLK_PROBE_STEP_EN.
package gb_probe_pkg;

  localparam int unsigned GB_ADR_W     = 16;
  localparam int unsigned LED_BYTE_LSB = 12;
  localparam int unsigned LED_CHAN_LSB = 8;
  localparam int unsigned LED_DATA_LSB = 0;

  typedef struct packed {
    logic [GB_ADR_W-1:0] adr;
    logic [GB_ADR_W-1:0] mask;
    logic                en;
    logic                wr;
  } match_cfg_t;

  // True when the bus cycle matches an enabled channel on the selected strobe.
  function automatic logic cfg_match(input match_cfg_t cfg, input logic [GB_ADR_W-1:0] adr,
                                     input logic n_rd, input logic n_wr);
    logic strobe;
    strobe = cfg.wr ? ~n_wr : ~n_rd;
    return cfg.en && strobe && (((adr ^ cfg.adr) & cfg.mask) == '0);
  endfunction

endpackage

// File: rtl/gb_clk_div.sv
// DMG clock divider: run control, phase counter, clkout and rise strobe.
// Single-step pulses are honoured only when GB_CLK_PROBE_STEP_EN is defined.
module gb_clk_div
  import gb_probe_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic halt,
  input  logic step,
  output logic clkout,
  output logic running,
  output logic rise_c
);

  localparam int unsigned HALF = 2 ** (DIV_W - 1);
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] phase_q, phase_d;
  logic             run_req_q, run_req_d;
  logic             running_q, running_d;
  logic             clkout_q, clkout_d;
  logic             step_go_c;

`ifdef GB_CLK_PROBE_STEP_EN
  // A step launches one period; it ends at the wrap unless start arrives meanwhile.
  assign step_go_c = step && !run_req_q && !running_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_go_c   = 1'b0;
`endif

  always_comb begin
    run_req_d = run_req_q;
    if (halt) begin
      run_req_d = 1'b0;
    end else if (start) begin
      run_req_d = 1'b1;
    end
    // Stopping is only allowed at the period boundary so clkout never runts.
    running_d = running_q;
    if (!running_q) begin
      running_d = run_req_d | step_go_c;
    end else if (phase_q == '1) begin
      running_d = run_req_d;
    end
    phase_d  = running_q ? phase_q + 1'b1 : '0;
    clkout_d = running_q && (phase_d >= DIV_W'(HALF));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      run_req_q <= 1'b0;
      running_q <= 1'b0;
      clkout_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      run_req_q <= run_req_d;
      running_q <= running_d;
      clkout_q  <= clkout_d;
    end
  end

  assign rise_c  = running_q && (phase_q == HALF_M1);
  assign clkout  = clkout_q;
  assign running = running_q;

endmodule

// File: rtl/gb_clk_probe.sv
// Game Boy clock generator with per-channel bus-event timestamps and LED readout.
// Define GB_CLK_PROBE_STEP_EN to enable single-step clocking via the step input.
module gb_clk_probe
  import gb_probe_pkg::*;
#(
  parameter int unsigned DIV_W      = 4,
  parameter int unsigned NCH        = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LED_SCAN_W = 21
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      halt,
  input  logic                      clear,
  input  logic                      step,
  input  logic [GB_ADR_W-1:0]       adr,
  input  logic                      n_rd,
  input  logic                      n_wr,
  input  logic [GB_ADR_W*NCH-1:0]   match_adr,
  input  logic [GB_ADR_W*NCH-1:0]   match_mask,
  input  logic [NCH-1:0]            match_en,
  input  logic [NCH-1:0]            match_wr,
  output logic                      clkout,
  output logic                      running,
  output logic [CNT_W-1:0]          count,
  output logic                      ovf,
  output logic [NCH-1:0]            hit,
  output logic [CNT_W*NCH-1:0]      ts,
  output logic [15:0]               led
);

  localparam int unsigned NB = CNT_W / 8;

  logic                  rise_c;
  match_cfg_t            cfg_c [NCH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [NCH-1:0]        hit_q, hit_d;
  logic [CNT_W-1:0]      ts_q [NCH];
  logic [CNT_W-1:0]      ts_d [NCH];
  logic [LED_SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]            byte_q, byte_d;
  logic [1:0]            chan_q, chan_d;
  logic [15:0]           led_q, led_d;
  logic [CNT_W-1:0]      sel_ts_c;
  logic                  sel_hit_c;
  logic [7:0]            sel_byte_c;

  gb_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .halt   (halt),
    .step   (step),
    .clkout (clkout),
    .running(running),
    .rise_c (rise_c)
  );

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cfg_c[i].adr  = match_adr[i*GB_ADR_W +: GB_ADR_W];
      cfg_c[i].mask = match_mask[i*GB_ADR_W +: GB_ADR_W];
      cfg_c[i].en   = match_en[i];
      cfg_c[i].wr   = match_wr[i];
    end
  end

  // DMG clock count and first-hit capture; clear outranks a coincident capture.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    hit_d   = hit_q;
    for (int i = 0; i < NCH; i++) ts_d[i] = ts_q[i];
    if (rise_c) begin
      count_d = count_q + 1'b1;
      if (count_q == '1) ovf_d = 1'b1;
    end
    if (clear) begin
      ovf_d = 1'b0;
      hit_d = '0;
      for (int i = 0; i < NCH; i++) ts_d[i] = '0;
    end else if (rise_c) begin
      for (int i = 0; i < NCH; i++) begin
        if (!hit_q[i] && cfg_match(cfg_c[i], adr, n_rd, n_wr)) begin
          hit_d[i] = 1'b1;
          ts_d[i]  = count_q;
        end
      end
    end
  end

  // LED scan walks bytes MSB-first within a channel, then the next channel.
  always_comb begin
    scan_d = scan_q + 1'b1;
    byte_d = byte_q;
    chan_d = chan_q;
    if (scan_q == '1) begin
      if (byte_q == 2'(NB - 1)) begin
        byte_d = '0;
        chan_d = (chan_q == 2'(NCH - 1)) ? 2'd0 : chan_q + 1'b1;
      end else begin
        byte_d = byte_q + 1'b1;
      end
    end
    sel_ts_c  = '0;
    sel_hit_c = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_q == 2'(i)) begin
        sel_ts_c  = ts_q[i];
        sel_hit_c = hit_q[i];
      end
    end
    sel_byte_c = '0;
    for (int b = 0; b < NB; b++) begin
      if (byte_q == 2'(b)) sel_byte_c = sel_ts_c[(NB-1-b)*8 +: 8];
    end
    led_d = '0;
    for (int b = 0; b < 4; b++) led_d[LED_BYTE_LSB + 3 - b] = (byte_q == 2'(b));
    for (int c = 0; c < 4; c++) led_d[LED_CHAN_LSB + c] = (chan_q == 2'(c));
    if (sel_hit_c) led_d[LED_DATA_LSB +: 8] = sel_byte_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      hit_q   <= '0;
      for (int i = 0; i < NCH; i++) ts_q[i] <= '0;
      scan_q  <= '0;
      byte_q  <= '0;
      chan_q  <= '0;
      led_q   <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
      for (int i = 0; i < NCH; i++) ts_q[i] <= ts_d[i];
      scan_q  <= scan_d;
      byte_q  <= byte_d;
      chan_q  <= chan_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ts[i*CNT_W +: CNT_W] = ts_q[i];
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign hit   = hit_q;
  assign led   = led_q;

endmodule

// File: tb/tb_gb_clk_probe.sv
// Directed bench for gb_clk_probe: three parameterisations cover waveform,
// capture, overflow and LED scan. Step checks follow GB_CLK_PROBE_STEP_EN.
module tb_gb_clk_probe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] adr;
  logic        n_rd, n_wr, step;

  // Instance A: DIV_W=4, NCH=2, CNT_W=16
  logic        a_start, a_halt, a_clear;
  logic [31:0] a_madr, a_mmask;
  logic [1:0]  a_men, a_mwr;
  logic        a_clkout, a_running, a_ovf;
  logic [15:0] a_count, a_led;
  logic [1:0]  a_hit;
  logic [31:0] a_ts;

  // Instance C: DIV_W=1, NCH=2, CNT_W=16, LED_SCAN_W=2
  logic        c_start, c_halt, c_clear;
  logic [31:0] c_madr, c_mmask;
  logic [1:0]  c_men, c_mwr;
  logic        c_clkout, c_running, c_ovf;
  logic [15:0] c_count, c_led;
  logic [1:0]  c_hit;
  logic [31:0] c_ts;

  // Instance B: DIV_W=4, NCH=1, CNT_W=8
  logic        b_start, b_halt, b_clear;
  logic [15:0] b_madr, b_mmask;
  logic        b_men, b_mwr;
  logic        b_clkout, b_running, b_ovf;
  logic [7:0]  b_count;
  logic [15:0] b_led;
  logic        b_hit;
  logic [7:0]  b_ts;

  gb_clk_probe #(.DIV_W(4), .NCH(2), .CNT_W(16), .LED_SCAN_W(2)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .halt(a_halt), .clear(a_clear), .step(step),
    .adr(adr), .n_rd(n_rd), .n_wr(n_wr), .match_adr(a_madr), .match_mask(a_mmask),
    .match_en(a_men), .match_wr(a_mwr), .clkout(a_clkout), .running(a_running),
    .count(a_count), .ovf(a_ovf), .hit(a_hit), .ts(a_ts), .led(a_led));

  gb_clk_probe #(.DIV_W(1), .NCH(2), .CNT_W(16), .LED_SCAN_W(2)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .halt(c_halt), .clear(c_clear), .step(1'b0),
    .adr(adr), .n_rd(n_rd), .n_wr(n_wr), .match_adr(c_madr), .match_mask(c_mmask),
    .match_en(c_men), .match_wr(c_mwr), .clkout(c_clkout), .running(c_running),
    .count(c_count), .ovf(c_ovf), .hit(c_hit), .ts(c_ts), .led(c_led));

  gb_clk_probe #(.DIV_W(4), .NCH(1), .CNT_W(8), .LED_SCAN_W(4)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .halt(b_halt), .clear(b_clear), .step(1'b0),
    .adr(adr), .n_rd(n_rd), .n_wr(n_wr), .match_adr(b_madr), .match_mask(b_mmask),
    .match_en(b_men), .match_wr(b_mwr), .clkout(b_clkout), .running(b_running),
    .count(b_count), .ovf(b_ovf), .hit(b_hit), .ts(b_ts), .led(b_led));

  // Edges since reset was last released; positions the LED scan.
  int ecnt = 0;
  always @(posedge clk) ecnt <= reset ? 0 : ecnt + 1;

  int total = 0;
  int bad   = 0;
  int n;

  typedef struct {
    int          k;
    logic [15:0] adr;
    logic        n_rd;
    logic        n_wr;
    logic        clr;
    logic [1:0]  hit;
    logic [15:0] ts0;
    logic [15:0] ts1;
  } cap_vec_t;

  cap_vec_t    vec [7];
  logic [15:0] led_seq [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int target);
    while (n < target) begin
      tick();
      n++;
    end
  endtask

  task automatic bus_idle();
    adr  = 16'h0000;
    n_rd = 1'b1;
    n_wr = 1'b1;
  endtask

  initial begin
    // k-th rise event; inputs are presented only during that cycle
    vec[0] = '{3, 16'h0100, 1'b1, 1'b1, 1'b0, 2'b00, 16'd0, 16'd0};
    vec[1] = '{4, 16'h0101, 1'b0, 1'b1, 1'b0, 2'b00, 16'd0, 16'd0};
    vec[2] = '{5, 16'h0100, 1'b0, 1'b1, 1'b1, 2'b00, 16'd0, 16'd0};
    vec[3] = '{6, 16'h0100, 1'b0, 1'b1, 1'b0, 2'b01, 16'd5, 16'd0};
    vec[4] = '{7, 16'h2ABC, 1'b0, 1'b1, 1'b0, 2'b01, 16'd5, 16'd0};
    vec[5] = '{8, 16'h2ABC, 1'b1, 1'b0, 1'b0, 2'b11, 16'd5, 16'd7};
    vec[6] = '{9, 16'h0100, 1'b0, 1'b0, 1'b0, 2'b11, 16'd5, 16'd7};
    led_seq[0] = 16'h8112;
    led_seq[1] = 16'h4134;
    led_seq[2] = 16'h8200;
    led_seq[3] = 16'h4200;

    reset = 1'b1; step = 1'b0;
    bus_idle();
    a_start = 0; a_halt = 0; a_clear = 0;
    a_madr = {16'h2000, 16'h0100}; a_mmask = {16'hF000, 16'hFFFF};
    a_men = 2'b11; a_mwr = 2'b10;
    c_start = 0; c_halt = 0; c_clear = 0;
    c_madr = {16'h0000, 16'h0100}; c_mmask = {16'hFFFF, 16'hFFFF};
    c_men = 2'b00; c_mwr = 2'b10;
    b_start = 0; b_halt = 0; b_clear = 0;
    b_madr = 16'h0000; b_mmask = 16'h0000; b_men = 1'b0; b_mwr = 1'b0;

    tick(); tick();
    check("rst_clkout",  64'(a_clkout),  64'(0));
    check("rst_running", 64'(a_running), 64'(0));
    check("rst_count",   64'(a_count),   64'(0));
    check("rst_ovf",     64'(a_ovf),     64'(0));
    check("rst_hit",     64'(a_hit),     64'(0));
    check("rst_ts",      64'(a_ts),      64'(0));
    check("rst_led",     64'(a_led),     64'(0));
    reset = 1'b0;
    tick();

    // Start pulse and clock waveform
    a_start = 1'b1; tick(); a_start = 1'b0; n = 0;
    check("start_running", 64'(a_running), 64'(1));
    check("start_clkout",  64'(a_clkout),  64'(0));
    for (int j = 1; j < 32; j++) begin
      tick(); n++;
      check($sformatf("wave_clkout_n%0d", n), 64'(a_clkout), 64'((n % 16) >= 8));
    end
    check("wave_count", 64'(a_count), 64'(2));

    // Capture vectors
    for (int v = 0; v < 7; v++) begin
      adv(16 * vec[v].k - 9);
      adr = vec[v].adr; n_rd = vec[v].n_rd; n_wr = vec[v].n_wr; a_clear = vec[v].clr;
      tick(); n++;
      bus_idle(); a_clear = 1'b0;
      check($sformatf("cap%0d_hit", vec[v].k),   64'(a_hit),        64'(vec[v].hit));
      check($sformatf("cap%0d_ts0", vec[v].k),   64'(a_ts[15:0]),   64'(vec[v].ts0));
      check($sformatf("cap%0d_ts1", vec[v].k),   64'(a_ts[31:16]),  64'(vec[v].ts1));
      check($sformatf("cap%0d_count", vec[v].k), 64'(a_count),      64'(vec[v].k));
    end
    adv(160);
    check("count_160", 64'(a_count), 64'(10));

    // Halt during the high phase completes the period
    adv(170);
    check("pre_halt_clkout", 64'(a_clkout), 64'(1));
    a_halt = 1'b1; tick(); n++; a_halt = 1'b0;
    check("halt_still_running", 64'(a_running), 64'(1));
    check("halt_still_high",    64'(a_clkout),  64'(1));
    adv(175);
    check("halt_last_high", 64'(a_clkout), 64'(1));
    adv(176);
    check("halt_stopped", 64'(a_running), 64'(0));
    check("halt_low",     64'(a_clkout),  64'(0));
    check("halt_count",   64'(a_count),   64'(11));
    repeat (40) tick();
    check("frozen_count",   64'(a_count),  64'(11));
    check("frozen_clkout",  64'(a_clkout), 64'(0));

    // start and halt together while stopped
    a_start = 1'b1; a_halt = 1'b1; tick(); a_start = 1'b0; a_halt = 1'b0;
    check("start_halt_run0", 64'(a_running), 64'(0));
    repeat (3) tick();
    check("start_halt_run1", 64'(a_running), 64'(0));
    check("start_halt_clk",  64'(a_clkout),  64'(0));

    // Idle clear drops hit/ts but keeps count
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    check("clear_hit",   64'(a_hit),   64'(0));
    check("clear_ts",    64'(a_ts),    64'(0));
    check("clear_count", 64'(a_count), 64'(11));

`ifdef GB_CLK_PROBE_STEP_EN
    step = 1'b1; tick(); step = 1'b0;
    check("step_running", 64'(a_running), 64'(1));
    repeat (16) tick();
    check("step_done",  64'(a_running), 64'(0));
    check("step_count", 64'(a_count),   64'(12));
`else
    step = 1'b1; tick(); step = 1'b0;
    check("step_ignored", 64'(a_running), 64'(0));
    repeat (16) tick();
    check("step_count", 64'(a_count), 64'(11));
`endif

    // Reset mid-run drops clkout at once
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (10) tick();
    check("midrun_high", 64'(a_clkout), 64'(1));
    reset = 1'b1; tick();
    check("midrun_rst_clkout",  64'(a_clkout),  64'(0));
    check("midrun_rst_running", 64'(a_running), 64'(0));
    check("midrun_rst_count",   64'(a_count),   64'(0));
    reset = 1'b0;

    // Instance C: capture at count 0x1234, then LED scan
    adr = 16'h0100; n_rd = 1'b0; n_wr = 1'b1;
    c_start = 1'b1; tick(); c_start = 1'b0; n = 0;
    adv(32'h2468);
    check("c_pre_hit", 64'(c_hit), 64'(0));
    c_men = 2'b01; tick(); n++; c_men = 2'b00;
    bus_idle();
    check("c_hit",   64'(c_hit),        64'(1));
    check("c_ts0",   64'(c_ts[15:0]),   64'(16'h1234));
    check("c_count", 64'(c_count),      64'(16'h1235));
    tick(); tick();
    for (int j = 0; j < 16; j++) begin
      tick();
      check($sformatf("led_e%0d", ecnt), 64'(c_led), 64'(led_seq[((ecnt - 1) / 4) % 4]));
    end

    // Instance B: 8-bit counter wrap
    b_start = 1'b1; tick(); b_start = 1'b0; n = 0;
    adv(4087);
    check("b_count_ff", 64'(b_count), 64'(8'hFF));
    check("b_ovf_pre",  64'(b_ovf),   64'(0));
    adv(4088);
    check("b_count_wrap", 64'(b_count), 64'(0));
    check("b_ovf_set",    64'(b_ovf),   64'(1));
    b_clear = 1'b1; tick(); n++; b_clear = 1'b0;
    check("b_ovf_clear",  64'(b_ovf),   64'(0));
    check("b_count_kept", 64'(b_count), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_clk_probe.md
Name: gb_clk_probe

Overview:
- Parametrised Game Boy clock generator and bus-event timestamper, fully in the FPGA `clk` domain.
- Drives the DMG X1 oscillator input from a divided `clk`, counts generated DMG clocks, and captures the count at the first matching bus access on each of NCH channels.
- Cycles the captured timestamps onto a 16-bit LED bank.
- Sits between the PLL and the SB_IO-registered bus inputs in the top level.

Parameters:
DIV_W, 4, divider width; clkout period = 2^DIV_W clk cycles, 50% duty
NCH, 4, number of match channels (1..4)
CNT_W, 32, DMG clock counter / timestamp width (8..32, multiple of 8)
LED_SCAN_W, 21, LED display advances every 2^LED_SCAN_W clk cycles

Ports:
clk  in  1  FPGA system clock (PLL output)
reset  in  1  synchronous, active-high reset
start  in  1  level/pulse; requests clocking
halt  in  1  level/pulse; requests stop at the end of the current DMG period
clear  in  1  pulse; clears hit/ts/ovf, leaves count
step  in  1  single-step request (used only with GB_CLK_PROBE_STEP_EN)
adr  in  16  registered bus address; bit 15 = !n_cs
n_rd  in  1  registered read strobe, active low
n_wr  in  1  registered write strobe, active low
match_adr  in  16*NCH  per-channel compare address
match_mask  in  16*NCH  per-channel mask; 1 = bit compared
match_en  in  NCH  channel enable
match_wr  in  NCH  1 = match writes (n_wr), 0 = match reads (n_rd)
clkout  out  1  DMG X1 clock
running  out  1  generator active
count  out  CNT_W  rising edges of clkout since reset
ovf  out  1  sticky; count wrapped
hit  out  NCH  sticky per-channel capture flag
ts  out  CNT_W*NCH  per-channel captured count
led  out  16  display bank

Behaviour:
- Reset values: all outputs 0, including clkout, running, count, ovf, hit, ts and led. Phase counter 0; LED scan state 0.
- Run control:
  - start sets run_req; halt clears it; halt wins if both are asserted in the same cycle.
  - running rises on the cycle after run_req is seen with phase == 0.
  - running falls only when phase wraps to 0, so no runt pulses; clkout is always low when stopped.
- Divider: while running, phase increments by 1 each clk and wraps at 2^DIV_W. clkout <= (phase_next ≥ 2^(DIV_W-1)), registered.
- Rise event R: the cycle in which running is high and phase == 2^(DIV_W-1)-1. The clkout register goes high on the same edge that acts on R.
- On R:
  - count <= count+1, wrapping mod 2^CNT_W. The wrap from all-ones to 0 sets ovf.
  - For each channel i, the channel captures if all of these hold: match_en[i], !hit[i], the selected strobe is low, and ((adr ^ match_adr[i]) & match_mask[i]) == 0. On capture: hit[i] <= 1, ts[i] <= count (value before increment).
- Channels evaluate independently; several may capture on the same R.
- clear: hit, ts and ovf are cleared next cycle. If clear coincides with R, clear wins and no capture occurs on that R.
- Reset mid-run: clkout drops to 0 immediately at the next edge; no completion of the period.
- LED scan:
  - A free-running divider of LED_SCAN_W bits counts clk. Each wrap advances {chan, byte}: byte = 0..CNT_W/8-1, MSB first, then chan = 0..NCH-1, then back to 0.
  - led[15:12] = one-hot byte index (bit 15 = most significant byte).
  - led[11:8] = one-hot channel.
  - led[7:0] = ts[chan] selected byte, or 0 if !hit[chan].

Optional Feature:
GB_CLK_PROBE_STEP_EN:
- Defined: while !running and !run_req, a step pulse generates exactly one full clkout period (2^DIV_W clk cycles, one R event, count +1, captures active). running is high for that period only. step while running is ignored; start during a step converts it to continuous run.
- Undefined: step is ignored and no step logic is synthesised.

Decomposition:
- Package gb_probe_pkg holds:
  - constant GB_ADR_W = 16
  - typedef for the match-channel configuration (adr, mask, en, wr)
  - LED field position constants
- One sub-module, gb_clk_div: phase counter, run control, clkout, rise strobe R, and the step logic. Matching, counting and the LED scan stay in the top block.

Test Plan:
- DIV_W=4, start pulse at t0 → running at t0+1, clkout high for clk cycles 8..15 of each period; after 160 cycles of running, count = 10.
- Ch0 match_adr=0x0100, mask=0xFFFF, read; n_rd low, adr=0x0100 during the 6th R → hit[0]=1, ts[0]=5; a later match leaves ts[0]=5.
- halt asserted while clkout is high → clkout completes its high phase, stops low at phase 0, running=0; count is frozen.
- start and halt in the same cycle while stopped → running stays 0. clear together with a matching R → hit stays 0.
- CNT_W=8: after 256 R events → count = 0 and ovf = 1; clear → ovf = 0, count unchanged.
- LED_SCAN_W=2, NCH=2, CNT_W=16, ts[0]=0x1234, ts[1] not hit → led sequence 0x8112, 0x4134, 0x8200, 0x4200, repeating every 16 clk cycles.
